pixel_collector: RTL and testbench

//  Sink end of the pixel stream: consumes pixel_out/pixel_valid from dut_top.

---
 rtl/pixel_pkg.sv | 19 +
 rtl/pixel_coord_counter.sv | 47 ++++
 rtl/pixel_collector.sv | 124 ++++++++++++
 tb/tb_pixel_collector.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types, default widths and the checksum fold for the pixel collector.
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } t_collector_state;

    localparam int DEF_PIXEL_W = 8;
    localparam int DEF_SIZE_W  = 12;
    localparam int DEF_COUNT_W = 24;

    // Rotate-left-by-one then xor in the (already zero-extended) pixel.
    function automatic logic [31:0] fold_pixel(input logic [31:0] cs, input logic [31:0] px);
        return {cs[30:0], cs[31]} ^ px;
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster x/y position counter. y is allowed to run to size_y after the last
// pixel so the final position reads (0, size_y).
module pixel_coord_counter #(
    parameter int SIZE_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [SIZE_W-1:0] size_x,
    input  logic [SIZE_W-1:0] size_y,
    output logic [SIZE_W-1:0] x_pos,
    output logic [SIZE_W-1:0] y_pos,
    output logic              last
);

    logic [SIZE_W-1:0] base_x, base_y;
    logic              row_end;

    // Clear and advance may coincide: the advance then starts from (0,0).
    always_comb begin
        base_x  = clr ? '0 : x_pos;
        base_y  = clr ? '0 : y_pos;
        row_end = (base_x == size_x - SIZE_W'(1));
        last    = row_end && (base_y == size_y - SIZE_W'(1));
    end

    // Position register: wrap x at the row end and step to the next row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (en) begin
            if (row_end) begin
                x_pos <= '0;
                y_pos <= base_y + SIZE_W'(1);
            end else begin
                x_pos <= base_x + SIZE_W'(1);
                y_pos <= base_y;
            end
        end else if (clr) begin
            x_pos <= '0;
            y_pos <= '0;
        end
    end

endmodule

// File: rtl/pixel_collector.sv
// Pixel stream sink: tracks raster position, counts pixels, folds them into a
// checksum, pulses frame_done at the end of a frame and flags stray pixels.
module pixel_collector
    import pixel_pkg::*;
#(
    parameter int PIXEL_W = DEF_PIXEL_W,
    parameter int SIZE_W  = DEF_SIZE_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SIZE_W-1:0]  size_x,
    input  logic [SIZE_W-1:0]  size_y,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_valid,
    output logic               busy,
    output logic [SIZE_W-1:0]  x_pos,
    output logic [SIZE_W-1:0]  y_pos,
    output logic [COUNT_W-1:0] pixel_count,
    output logic [31:0]        checksum,
    output logic               frame_done,
    output logic               overrun
);

    t_collector_state  state;
    logic [SIZE_W-1:0]  sx_q, sy_q;
    logic [COUNT_W-1:0] total_q;

    logic               is_start, size_zero, accept, last_pix, count_last, coord_last;
    logic [SIZE_W-1:0]  cur_sx, cur_sy;
    logic [COUNT_W-1:0] cur_total, cnt_base, cnt_inc;
    logic [31:0]        cs_base, cs_next;

    // Start-cycle bypass: a pixel arriving with start is pixel 0 of the new
    // frame, so geometry, count and checksum come from the fresh values.
    always_comb begin
        is_start   = (state == IDLE) && start;
        size_zero  = (size_x == '0) || (size_y == '0);
        accept     = pixel_valid && ((state == COLLECT) || (is_start && !size_zero));
        cur_sx     = (state == IDLE) ? size_x : sx_q;
        cur_sy     = (state == IDLE) ? size_y : sy_q;
        cur_total  = is_start ? (COUNT_W'(size_x) * COUNT_W'(size_y)) : total_q;
        cnt_base   = is_start ? '0 : pixel_count;
        cs_base    = is_start ? '0 : checksum;
        cnt_inc    = cnt_base + COUNT_W'(1);
        cs_next    = fold_pixel(cs_base, 32'(pixel_in));
        count_last = (cnt_inc == cur_total);
        // Count and raster position agree for any nonzero geometry.
        last_pix   = accept && (count_last || coord_last);
    end

    pixel_coord_counter #(.SIZE_W(SIZE_W)) u_coord (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (is_start),
        .en     (accept),
        .size_x (cur_sx),
        .size_y (cur_sy),
        .x_pos  (x_pos),
        .y_pos  (y_pos),
        .last   (coord_last)
    );

    // Frame FSM with registered busy/frame_done/overrun and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            total_q     <= '0;
            pixel_count <= '0;
            checksum    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sx_q        <= size_x;
                        sy_q        <= size_y;
                        total_q     <= cur_total;
                        pixel_count <= accept ? cnt_inc : '0;
                        checksum    <= accept ? cs_next : '0;
                        // A pixel alongside a zero-size start has no frame to land in.
                        overrun     <= pixel_valid && size_zero;
                        if (size_zero || last_pix) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state <= COLLECT;
                            busy  <= 1'b1;
                        end
                    end else if (pixel_valid) begin
                        overrun <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        pixel_count <= cnt_inc;
                        checksum    <= cs_next;
                        if (last_pix) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (pixel_valid) overrun <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_collector.sv
// Directed vector bench for pixel_collector.
module tb_pixel_collector;

    logic        clk, rst_n, start, pixel_valid;
    logic [11:0] size_x, size_y;
    logic [7:0]  pixel_in;
    logic        busy, frame_done, overrun;
    logic [11:0] x_pos, y_pos;
    logic [23:0] pixel_count;
    logic [31:0] checksum;

    pixel_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .size_x      (size_x),
        .size_y      (size_y),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .busy        (busy),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pixel_count (pixel_count),
        .checksum    (checksum),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic [11:0] sx, sy;
        logic        pv;
        logic [7:0]  px;
        logic        busy;
        logic [11:0] x, y;
        logic [23:0] cnt;
        logic [31:0] cs;
        logic        done;
        logic        ovr;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] fold(input logic [31:0] c, input logic [7:0] p);
        return {c[30:0], c[31]} ^ {24'd0, p};
    endfunction

    function automatic vec_t mk(input string n, input logic st, input int sx, input int sy,
                                input logic pv, input int px, input logic b, input int x,
                                input int y, input int cnt, input logic [31:0] cs,
                                input logic d, input logic o);
        vec_t v;
        v.name = n; v.st = st; v.sx = 12'(sx); v.sy = 12'(sy); v.pv = pv; v.px = 8'(px);
        v.busy = b; v.x = 12'(x); v.y = 12'(y); v.cnt = 24'(cnt); v.cs = cs;
        v.done = d; v.ovr = o;
        return v;
    endfunction

    task automatic check(input vec_t v);
        n_vec++;
        if ({busy, x_pos, y_pos, pixel_count, checksum, frame_done, overrun} !==
            {v.busy, v.x, v.y, v.cnt, v.cs, v.done, v.ovr}) begin
            n_bad++;
            $display("FAIL %s: got busy=%0b x=%0d y=%0d cnt=%0d cs=%h done=%0b ovr=%0b; want busy=%0b x=%0d y=%0d cnt=%0d cs=%h done=%0b ovr=%0b",
                     v.name, busy, x_pos, y_pos, pixel_count, checksum, frame_done, overrun,
                     v.busy, v.x, v.y, v.cnt, v.cs, v.done, v.ovr);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        start = v.st; size_x = v.sx; size_y = v.sy; pixel_valid = v.pv; pixel_in = v.px;
        @(posedge clk);
        #1;
        check(v);
    endtask

    initial begin
        logic [31:0] cs;
        int          early;

        rst_n = 1'b0; start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
        size_x = '0; size_y = '0;
        #23;
        check(mk("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 4x3 back-to-back
        cs = 0;
        vq.push_back(mk("t1_start", 1, 4, 3, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        for (int i = 1; i <= 12; i++) begin
            cs = fold(cs, 8'(i));
            vq.push_back(mk($sformatf("t1_px%0d", i), 0, 4, 3, 1, i, i < 12, i % 4, i / 4, i, cs, i == 12, 0));
        end
        vq.push_back(mk("t1_hold", 0, 4, 3, 0, 0, 0, 0, 3, 12, cs, 0, 0));

        // 2: same frame with gaps
        cs = 0;
        vq.push_back(mk("t2_start", 1, 4, 3, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        for (int i = 1; i <= 12; i++) begin
            cs = fold(cs, 8'(i));
            vq.push_back(mk($sformatf("t2_px%0d", i), 0, 4, 3, 1, i, i < 12, i % 4, i / 4, i, cs, i == 12, 0));
            if (i < 12)
                vq.push_back(mk($sformatf("t2_gap%0d", i), 0, 4, 3, 0, 0, 1, i % 4, i / 4, i, cs, 0, 0));
        end
        vq.push_back(mk("t2_hold", 0, 4, 3, 0, 0, 0, 0, 3, 12, cs, 0, 0));

        // 3: stray pixel in IDLE, then a start clears it; 2x1 frame with pixel in start cycle
        vq.push_back(mk("t3_stray", 0, 4, 3, 1, 9, 0, 0, 3, 12, cs, 0, 1));
        vq.push_back(mk("t3_start_px0", 1, 2, 1, 1, 'hA5, 1, 1, 0, 1, 32'h0000_00A5, 0, 0));
        vq.push_back(mk("t3_last", 0, 2, 1, 1, 'h3C, 0, 0, 1, 2, 32'h0000_0176, 1, 0));
        vq.push_back(mk("t3_px_in_done", 0, 2, 1, 1, 'h11, 0, 0, 1, 2, 32'h0000_0176, 0, 1));

        // 4: zero-size frames
        vq.push_back(mk("t4_zero_x_px", 1, 0, 5, 1, 7, 0, 0, 0, 0, 32'h0, 1, 1));
        vq.push_back(mk("t4_idle", 0, 0, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1));
        vq.push_back(mk("t4_zero_y", 1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
        vq.push_back(mk("t4_idle2", 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));

        // 5: start during COLLECT ignored; start in DONE ignored
        cs = 0;
        vq.push_back(mk("t5_start", 1, 4, 3, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        for (int i = 1; i <= 12; i++) begin
            cs = fold(cs, 8'(i));
            vq.push_back(mk($sformatf("t5_px%0d", i), i == 6, i == 6 ? 2 : 4, i == 6 ? 2 : 3, 1, i,
                            i < 12, i % 4, i / 4, i, cs, i == 12, 0));
        end
        vq.push_back(mk("t5_start_in_done", 1, 5, 5, 0, 0, 0, 0, 3, 12, cs, 0, 0));
        vq.push_back(mk("t5_idle", 0, 5, 5, 0, 0, 0, 0, 3, 12, cs, 0, 0));

        foreach (vq[i]) apply(vq[i]);

        // 6: async reset mid 40x40 frame, then a full frame
        cs = 0;
        apply(mk("t6_start", 1, 40, 40, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        for (int k = 1; k <= 6; k++) begin
            cs = fold(cs, 8'(k + 100));
            apply(mk($sformatf("t6_px%0d", k), 0, 40, 40, 1, k + 100, 1, k, 0, k, cs, 0, 0));
        end
        @(negedge clk);
        start = 1'b0; pixel_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check(mk("t6_async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check(mk($sformatf("t6_reset_hold%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        cs = 0;
        early = 0;
        apply(mk("t6_restart", 1, 40, 40, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        for (int k = 1; k < 1600; k++) begin
            @(negedge clk);
            start = 1'b0; pixel_valid = 1'b1; pixel_in = 8'((k * 7 + 3) & 255);
            cs = fold(cs, pixel_in);
            @(posedge clk);
            #1;
            if (frame_done || !busy) early++;
        end
        cs = fold(cs, 8'((1600 * 7 + 3) & 255));
        apply(mk("t6_last", 0, 40, 40, 1, (1600 * 7 + 3) & 255, 0, 0, 40, 1600, cs, 1, 0));
        n_vec++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL t6_busy_no_early_done: got %0d bad cycles, want 0", early);
        end
        apply(mk("t6_hold", 0, 40, 40, 0, 0, 0, 0, 40, 1600, cs, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
